// File: rtl/stw_bist_sequencer.sv
// stw_bist_sequencer: applies a programmable table of STW test vectors to the
// systolic array back-to-back and accumulates a sticky per-PE fault map,
// a fault count and a timeout flag.
//
// Registered outputs are computed from the next state, so each strobe is high
// during the same cycle as the state that owns it: LOAD <-> STW_test_load_en,
// START <-> STW_start, DONE <-> done.
module stw_bist_sequencer #(
    parameter int unsigned ROWS           = 4,
    parameter int unsigned COLS           = 4,
    parameter int unsigned WORD_SIZE      = 16,
    parameter int unsigned NUM_PATTERNS   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 32,
    localparam int unsigned PE_NUM = ROWS * COLS,
    localparam int unsigned CNT_W  = $clog2(NUM_PATTERNS) + 1,
    localparam int unsigned ADDR_W = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1,
    localparam int unsigned FC_W   = $clog2(PE_NUM + 1),
    localparam int unsigned VEC_W  = 4 * WORD_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_W-1:0]     cfg_num_patterns,
    input  logic                 pat_wr_en,
    input  logic [ADDR_W-1:0]    pat_wr_addr,
    input  logic [VEC_W-1:0]     pat_wr_data,
    output logic                 STW_test_load_en,
    output logic [WORD_SIZE-1:0] STW_mult_op1,
    output logic [WORD_SIZE-1:0] STW_mult_op2,
    output logic [WORD_SIZE-1:0] STW_add_op,
    output logic [WORD_SIZE-1:0] STW_expected,
    output logic                 STW_start,
    input  logic                 STW_complete,
    input  logic [PE_NUM-1:0]    STW_result_mat,
    output logic [PE_NUM-1:0]    fault_map,
    output logic [FC_W-1:0]      fault_count,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout_err
);

    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        START   = 3'd2,
        WAIT    = 3'd3,
        CAPTURE = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t state_q, state_d;

    logic [VEC_W-1:0]  pat_q [NUM_PATTERNS];
    logic [ADDR_W-1:0] p_q, p_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [VEC_W-1:0]  vec_q, vec_d;
    logic [PE_NUM-1:0] fault_map_q, fault_map_d;
    logic [FC_W-1:0]   fault_count_q, fault_count_d;
    logic              timeout_err_q, timeout_err_d;
    logic              load_en_q, load_en_d;
    logic              stw_start_q, stw_start_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              wr_addr_ok;
    logic [CNT_W-1:0]  num_clamped;
    logic [VEC_W-1:0]  entry0;
    logic [ADDR_W-1:0] p_inc;
    logic [TO_W-1:0]   to_cnt_inc;

    function automatic logic [FC_W-1:0] popcount(input logic [PE_NUM-1:0] v);
        logic [FC_W-1:0] n;
        n = '0;
        for (int unsigned i = 0; i < PE_NUM; i++) begin
            n = n + FC_W'(v[i]);
        end
        return n;
    endfunction

    // Helper terms: address check, clamped run length, entry-0 write bypass.
    always_comb begin
        wr_addr_ok = 32'(pat_wr_addr) < NUM_PATTERNS;
        if (cfg_num_patterns == '0) begin
            num_clamped = CNT_W'(1);
        end else if (cfg_num_patterns > CNT_W'(NUM_PATTERNS)) begin
            num_clamped = CNT_W'(NUM_PATTERNS);
        end else begin
            num_clamped = cfg_num_patterns;
        end
        // A write landing on the start cycle must be seen by the first LOAD.
        entry0     = (pat_wr_en && (pat_wr_addr == '0)) ? pat_wr_data : pat_q[0];
        p_inc      = p_q + ADDR_W'(1);
        to_cnt_inc = to_cnt_q + TO_W'(1);
    end

    // Pattern table: default vectors on reset, writes accepted only in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < NUM_PATTERNS; k++) begin
                pat_q[k] <= {WORD_SIZE'(12 + k), WORD_SIZE'(k), WORD_SIZE'(3), WORD_SIZE'(4)};
            end
        end else if ((state_q == IDLE) && pat_wr_en && wr_addr_ok) begin
            pat_q[pat_wr_addr] <= pat_wr_data;
        end
    end

    // State and registered-output flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            p_q           <= '0;
            last_q        <= '0;
            to_cnt_q      <= '0;
            vec_q         <= '0;
            fault_map_q   <= '0;
            fault_count_q <= '0;
            timeout_err_q <= 1'b0;
            load_en_q     <= 1'b0;
            stw_start_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            p_q           <= p_d;
            last_q        <= last_d;
            to_cnt_q      <= to_cnt_d;
            vec_q         <= vec_d;
            fault_map_q   <= fault_map_d;
            fault_count_q <= fault_count_d;
            timeout_err_q <= timeout_err_d;
            load_en_q     <= load_en_d;
            stw_start_q   <= stw_start_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state_q;
        p_d           = p_q;
        last_d        = last_q;
        to_cnt_d      = to_cnt_q;
        vec_d         = vec_q;
        fault_map_d   = fault_map_q;
        fault_count_d = fault_count_q;
        timeout_err_d = timeout_err_q;
        load_en_d     = 1'b0;
        stw_start_d   = 1'b0;
        done_d        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d       = LOAD;
                    p_d           = '0;
                    last_d        = ADDR_W'(num_clamped - CNT_W'(1));
                    fault_map_d   = '0;
                    fault_count_d = '0;
                    timeout_err_d = 1'b0;
                    load_en_d     = 1'b1;
                    vec_d         = entry0;
                end
            end
            LOAD: begin
                state_d     = START;
                stw_start_d = 1'b1;
                to_cnt_d    = '0;
            end
            START: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (STW_complete) begin
                    state_d     = CAPTURE;
                    fault_map_d = fault_map_q | ~STW_result_mat;
                end else begin
                    to_cnt_d = to_cnt_inc;
                    if (to_cnt_inc == TO_W'(TIMEOUT_CYCLES)) begin
                        state_d       = DONE;
                        fault_map_d   = '1;
                        fault_count_d = FC_W'(PE_NUM);
                        timeout_err_d = 1'b1;
                        done_d        = 1'b1;
                    end
                end
            end
            CAPTURE: begin
                if (p_q == last_q) begin
                    state_d       = DONE;
                    fault_count_d = popcount(fault_map_q);
                    done_d        = 1'b1;
                end else begin
                    state_d   = LOAD;
                    p_d       = p_inc;
                    load_en_d = 1'b1;
                    vec_d     = pat_q[p_inc];
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign STW_test_load_en = load_en_q;
    assign STW_start        = stw_start_q;
    assign STW_mult_op1     = vec_q[0*WORD_SIZE +: WORD_SIZE];
    assign STW_mult_op2     = vec_q[1*WORD_SIZE +: WORD_SIZE];
    assign STW_add_op       = vec_q[2*WORD_SIZE +: WORD_SIZE];
    assign STW_expected     = vec_q[3*WORD_SIZE +: WORD_SIZE];
    assign fault_map        = fault_map_q;
    assign fault_count      = fault_count_q;
    assign timeout_err      = timeout_err_q;
    assign busy             = busy_q;
    assign done             = done_q;

endmodule

// File: tb/tb_stw_bist_sequencer.sv
// Directed testbench for stw_bist_sequencer with a small array model that
// answers STW_start after a fixed latency and returns programmable results.
module tb_stw_bist_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  cfg_num_patterns;
    logic        pat_wr_en;
    logic [1:0]  pat_wr_addr;
    logic [63:0] pat_wr_data;
    logic        STW_test_load_en;
    logic [15:0] STW_mult_op1, STW_mult_op2, STW_add_op, STW_expected;
    logic        STW_start;
    logic        STW_complete;
    logic [15:0] STW_result_mat;
    logic [15:0] fault_map;
    logic [4:0]  fault_count;
    logic        busy, done, timeout_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [15:0] fault_mask, int_mask, int_pat;
    logic        model_hang;
    int          m_cnt;
    logic [63:0] load_log [$];

    stw_bist_sequencer #(
        .ROWS(4), .COLS(4), .WORD_SIZE(16), .NUM_PATTERNS(4), .TIMEOUT_CYCLES(32)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_num_patterns(cfg_num_patterns),
        .pat_wr_en(pat_wr_en), .pat_wr_addr(pat_wr_addr), .pat_wr_data(pat_wr_data),
        .STW_test_load_en(STW_test_load_en), .STW_mult_op1(STW_mult_op1),
        .STW_mult_op2(STW_mult_op2), .STW_add_op(STW_add_op), .STW_expected(STW_expected),
        .STW_start(STW_start), .STW_complete(STW_complete), .STW_result_mat(STW_result_mat),
        .fault_map(fault_map), .fault_count(fault_count), .busy(busy), .done(done),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Array model: complete pulses 5 cycles after STW_start is seen.
    always @(posedge clk or posedge rst) begin
        if (rst) m_cnt <= 0;
        else if (STW_start && !model_hang) m_cnt <= 5;
        else if (m_cnt != 0) m_cnt <= m_cnt - 1;
    end
    assign STW_complete   = (m_cnt == 1);
    assign STW_result_mat = ~(fault_mask | ((STW_add_op == int_pat) ? int_mask : 16'h0));

    // Record each applied vector.
    always @(negedge clk) begin
        if (STW_test_load_en)
            load_log.push_back({STW_expected, STW_add_op, STW_mult_op2, STW_mult_op1});
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input logic [2:0] n);
        start            = 1'b1;
        cfg_num_patterns = n;
        step(1);
        start            = 1'b0;
    endtask

    task automatic wait_done(input int t0, input int max, input int exp_lat, input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < max) begin
            step(1);
            n++;
        end
        chk({tag, "_done"}, 64'(done), 64'(1));
        chk({tag, "_lat"}, 64'(cyc - t0), 64'(exp_lat));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_load_en"}, 64'(STW_test_load_en), 64'(0));
        chk({tag, "_stw_start"}, 64'(STW_start), 64'(0));
        chk({tag, "_vec"}, {STW_expected, STW_add_op, STW_mult_op2, STW_mult_op1}, 64'(0));
        chk({tag, "_fault_map"}, 64'(fault_map), 64'(0));
        chk({tag, "_fault_count"}, 64'(fault_count), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_done"}, 64'(done), 64'(0));
        chk({tag, "_timeout_err"}, 64'(timeout_err), 64'(0));
    endtask

    initial begin
        int t0;
        rst = 1'b1; start = 1'b0; cfg_num_patterns = 3'd1;
        pat_wr_en = 1'b0; pat_wr_addr = 2'd0; pat_wr_data = 64'd0;
        fault_mask = 16'h0; int_mask = 16'h0; int_pat = 16'h0; model_hang = 1'b0;
        step(3);
        chk_all_zero("reset");
        rst = 1'b0;
        step(1);

        // 1: single default pattern, clean array
        load_log.delete();
        t0 = cyc;
        pulse_start(3'd1);
        chk("t1_load_en", 64'(STW_test_load_en), 64'(1));
        chk("t1_vec", {STW_expected, STW_add_op, STW_mult_op2, STW_mult_op1},
            {16'd12, 16'd0, 16'd3, 16'd4});
        chk("t1_busy", 64'(busy), 64'(1));
        step(1);
        chk("t1_stw_start", 64'(STW_start), 64'(1));
        chk("t1_load_en_low", 64'(STW_test_load_en), 64'(0));
        wait_done(t0, 40, 9, "t1");
        chk("t1_fault_map", 64'(fault_map), 64'h0);
        chk("t1_fault_count", 64'(fault_count), 64'd0);
        chk("t1_timeout_err", 64'(timeout_err), 64'd0);
        step(1);
        chk("t1_done_pulse", 64'(done), 64'(0));
        chk("t1_busy_idle", 64'(busy), 64'(0));

        // 2: stuck faults at bits 1 and 12, four patterns
        fault_mask = 16'h1002;
        load_log.delete();
        t0 = cyc;
        pulse_start(3'd4);
        wait_done(t0, 100, 33, "t2");
        chk("t2_loads", 64'(load_log.size()), 64'd4);
        for (int k = 0; k < 4 && k < load_log.size(); k++)
            chk("t2_vec", load_log[k], {16'(12 + k), 16'(k), 16'd3, 16'd4});
        chk("t2_fault_map", 64'(fault_map), 64'h1002);
        chk("t2_fault_count", 64'(fault_count), 64'd2);
        chk("t2_timeout_err", 64'(timeout_err), 64'd0);
        step(1);

        // 3: intermittent fault on bit 5 during pattern 2 only
        fault_mask = 16'h0; int_pat = 16'd2; int_mask = 16'h0020;
        t0 = cyc;
        pulse_start(3'd4);
        wait_done(t0, 100, 33, "t3");
        chk("t3_fault_map", 64'(fault_map), 64'h0020);
        chk("t3_fault_count", 64'(fault_count), 64'd1);
        int_mask = 16'h0;
        step(1);

        // 4: array never completes
        model_hang = 1'b1;
        t0 = cyc;
        pulse_start(3'd1);
        wait_done(t0, 60, 35, "t4");
        chk("t4_timeout_err", 64'(timeout_err), 64'd1);
        chk("t4_fault_map", 64'(fault_map), 64'hFFFF);
        chk("t4_fault_count", 64'(fault_count), 64'd16);
        step(1);
        chk("t4_err_hold", 64'(timeout_err), 64'd1);
        model_hang = 1'b0;

        // 5: table write while idle; write during busy is dropped
        pat_wr_en = 1'b1; pat_wr_addr = 2'd0; pat_wr_data = {16'd44, 16'd2, 16'd6, 16'd7};
        step(1);
        pat_wr_en = 1'b0;
        load_log.delete();
        t0 = cyc;
        pulse_start(3'd1);
        chk("t5_err_cleared", 64'(timeout_err), 64'd0);
        step(2);
        pat_wr_en = 1'b1; pat_wr_data = {16'd99, 16'd9, 16'd9, 16'd9};
        step(1);
        pat_wr_en = 1'b0;
        wait_done(t0, 40, 9, "t5a");
        chk("t5a_vec", load_log[0], {16'd44, 16'd2, 16'd6, 16'd7});
        step(1);
        load_log.delete();
        t0 = cyc;
        pulse_start(3'd1);
        wait_done(t0, 40, 9, "t5b");
        chk("t5b_vec", load_log[0], {16'd44, 16'd2, 16'd6, 16'd7});
        step(1);
        // write and start in the same cycle
        load_log.delete();
        pat_wr_en = 1'b1; pat_wr_data = {16'd21, 16'd1, 16'd2, 16'd3};
        t0 = cyc;
        pulse_start(3'd1);
        pat_wr_en = 1'b0;
        wait_done(t0, 40, 9, "t5c");
        chk("t5c_vec", load_log[0], {16'd21, 16'd1, 16'd2, 16'd3});
        step(1);

        // 6: reset mid-run, then a fresh run with defaults
        fault_mask = 16'h0001;
        load_log.delete();
        pulse_start(3'd4);
        step(18);
        chk("t6_pre_add", 64'(STW_add_op), 64'd2);
        chk("t6_pre_map", 64'(fault_map), 64'h0001);
        rst = 1'b1;
        #1;
        chk_all_zero("t6_rst");
        step(1);
        rst = 1'b0;
        fault_mask = 16'h0;
        step(1);
        load_log.delete();
        t0 = cyc;
        pulse_start(3'd0);
        step(2);
        start = 1'b1;
        step(1);
        start = 1'b0;
        wait_done(t0, 40, 9, "t6");
        chk("t6_loads", 64'(load_log.size()), 64'd1);
        chk("t6_vec", load_log[0], {16'd12, 16'd0, 16'd3, 16'd4});
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("t6_start_in_done", 64'(busy), 64'd0);
        t0 = cyc;
        pulse_start(3'd1);
        chk("t6_restart_busy", 64'(busy), 64'd1);
        wait_done(t0, 40, 9, "t6r");
        chk("t6_loads_total", 64'(load_log.size()), 64'd2);
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stw_bist_sequencer.md
Name: stw_bist_sequencer

Overview:
- Multi-pattern stop-the-world (STW) diagnosis sequencer for the stw_wproxy_systolic array.
- Replaces single-vector, bench-driven STW sequencing with a programmable table of NUM_PATTERNS test vectors, applied back-to-back through the array's STW port.
- Accumulates a sticky per-PE fault map, a fault count and a timeout error.
- Sits between the top-level controller and the array's STW_* pins; runs before and after matmul jobs.

Parameters:
- ROWS, 4, PE rows in the array.
- COLS, 4, PE columns in the array.
- WORD_SIZE, 16, operand width.
- NUM_PATTERNS, 4, pattern table depth (>=1).
- TIMEOUT_CYCLES, 32, maximum cycles spent in WAIT before the run aborts.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle request to begin a diagnosis run; ignored while busy.
- cfg_num_patterns  in  $clog2(NUM_PATTERNS)+1  patterns to apply; 0 is treated as 1; values >NUM_PATTERNS clamp to NUM_PATTERNS; sampled on the start cycle.
- pat_wr_en  in  1  pattern table write strobe.
- pat_wr_addr  in  $clog2(NUM_PATTERNS) (min 1)  table entry index.
- pat_wr_data  in  4*WORD_SIZE  packed {expected, add_op, mult_op2, mult_op1}, mult_op1 in the LSBs.
- STW_test_load_en  out  1  load strobe to the array.
- STW_mult_op1, STW_mult_op2, STW_add_op, STW_expected  out  WORD_SIZE each  current vector.
- STW_start  out  1  test start strobe.
- STW_complete  in  1  array reports the test finished.
- STW_result_mat  in  ROWS*COLS  per-PE pass bits (1 = no fault); bit index c*ROWS+r.
- fault_map  out  ROWS*COLS  sticky fault bits (1 = faulty); same indexing.
- fault_count  out  $clog2(ROWS*COLS+1)  popcount of fault_map.
- busy  out  1  high from LOAD through DONE.
- done  out  1  one-cycle pulse at run end.
- timeout_err  out  1  last run aborted on timeout.

Behaviour:
- All outputs are registered.
- Reset (asynchronous, any time, including mid-run):
  - FSM returns to IDLE.
  - All STW_* outputs, fault_map, fault_count, busy, done and timeout_err go to 0.
  - Pattern entry k reloads {expected=12+k, add=k, op2=3, op1=4}.
- Table writes:
  - Accepted only when the FSM is in IDLE; writes in any other state are dropped.
  - A write and start in the same IDLE cycle: the write lands and the run uses the new data.
  - Out-of-range pat_wr_addr is ignored.
- FSM states: IDLE, LOAD, START, WAIT, CAPTURE, DONE.
- IDLE:
  - On start: clear fault_map, fault_count and timeout_err; latch the clamped pattern count N; set pattern index p=0; go to LOAD.
- LOAD (1 cycle):
  - STW_test_load_en=1.
  - STW_mult_op1/op2/add_op/expected driven from entry p; they hold those values until the next LOAD.
  - Go to START.
- START (1 cycle):
  - STW_start=1; clear the timeout counter; go to WAIT.
- WAIT:
  - If STW_complete is sampled high, go to CAPTURE.
  - Otherwise increment the counter. When the counter reaches TIMEOUT_CYCLES: set fault_map to all ones, set timeout_err=1, go to DONE.
  - STW_complete already high on the first WAIT cycle is accepted.
- CAPTURE (1 cycle):
  - fault_map |= ~STW_result_mat.
  - If p==N-1, go to DONE; else p++ and go to LOAD.
- DONE (1 cycle):
  - done=1; fault_count = popcount(fault_map); go to IDLE.
- busy is 1 in LOAD, START, WAIT, CAPTURE and DONE; 0 in IDLE.
- Timing from a start sampled at edge 0:
  - load_en is high after edge 1.
  - STW_start is high after edge 2.
  - WAIT is entered after edge 3.
  - Per-pattern cost is 3 cycles plus the WAIT dwell.
- Hold behaviour:
  - fault_map, fault_count and timeout_err hold until the next accepted start.
  - start during busy has no effect, including during DONE.
  - The FSM remains in IDLE for at least 1 cycle after DONE; a start sampled in that cycle is accepted.

Test Plan:
1. Reset defaults, start, cfg_num_patterns=1, array model asserts STW_complete 5 cycles after STW_start with all-ones results -> vector 4,3,0,12 applied; done 9 cycles after start; fault_map=0, fault_count=0, timeout_err=0.
2. Fault injected at (r=1,c=0) and (r=0,c=3) so the model returns result bits 1 and 12 low, cfg_num_patterns=4 -> four LOAD/START pairs with add=0..3 and expected=12..15; fault_map=0x1002; fault_count=2.
3. Intermittent fault: PE bit 5 fails only on pattern 2 -> bit 5 stays set in the final map (sticky OR); fault_count=1.
4. Model never asserts STW_complete -> timeout_err=1 exactly TIMEOUT_CYCLES cycles after WAIT entry; fault_map=0xFFFF; fault_count=16; done pulses.
5. Write entry 0 = {op1=7, op2=6, add=2, exp=44} while idle; then write entry 0 again during busy -> the run drives 7,6,2,44 and the busy-time write is dropped (entry readback through a following run is unchanged).
6. Assert rst during WAIT of pattern 2 -> all outputs zero immediately; a fresh start runs from p=0 with default patterns; start pulsed while busy is ignored; cfg_num_patterns=0 runs exactly 1 pattern.
